// File: rtl/mips_seq_alu.sv
// rtl/mips_seq_alu.sv - registered execute-stage ALU with an iterative shift-add MUL.
// Optional build macro MIPS_ALU_RADIX4_MUL_EN retires two multiplier bits per cycle.
module mips_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam int CW = $clog2(WIDTH);
`ifdef MIPS_ALU_RADIX4_MUL_EN
  localparam int             SHIFT = 2;
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH/2 - 1);
`else
  localparam int             SHIFT = 1;
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_sum;

  // 011 and 111 fall into the ADD default; 101 is handled by the MUL path
  always_comb begin
    alu_out = SrcA + SrcB;
    case (ALUControl)
      3'b000:  alu_out = SrcA & SrcB;
      3'b001:  alu_out = SrcA | SrcB;
      3'b100:  alu_out = SrcA - SrcB;
      3'b110:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_out = SrcA + SrcB;
    endcase
  end

  always_comb begin
`ifdef MIPS_ALU_RADIX4_MUL_EN
    partial = (mplier_q[0] ? mcand_q : '0) + (mplier_q[1] ? (mcand_q << 1) : '0);
`else
    partial = mplier_q[0] ? mcand_q : '0;
`endif
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUControl == 3'b101) begin
            mcand_d  = SrcA;
            mplier_d = SrcB;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << SHIFT;
        mplier_d = mplier_q >> SHIFT;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;

endmodule

// File: tb/tb_mips_seq_alu.sv
// tb/tb_mips_seq_alu.sv - directed scoreboard bench for mips_seq_alu.
module tb_mips_seq_alu;

`ifdef MIPS_ALU_RADIX4_MUL_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ALUControl = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mips_seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and retire a scoreboard entry on done.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    check("busy_done_excl", 32'(busy & done), 32'd0);
    if (done) begin
      check("done_has_expect", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", ALUResult, e);
        check("zero", 32'(Zero), 32'(e == 32'd0));
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    exp_q.push_back(exp);
    tick();
    check("single_done", 32'(done), 32'd1);
  endtask

  task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input logic [31:0] prev, input bit inject);
    int n;
    start = 1'b1; ALUControl = 3'b101; SrcA = a; SrcB = b;
    exp_q.push_back(exp);
    tick();
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 3) begin
        start = 1'b1; ALUControl = 3'b010; SrcA = 32'd1; SrcB = 32'd2;
      end else begin
        start = 1'b0; SrcA = ~SrcA;
      end
      check("mul_hold", ALUResult, prev);
      tick();
    end
    start = 1'b0;
    check("mul_busy_cycles", 32'(n), 32'(MUL_LAT));
    check("mul_done", 32'(done), 32'd1);
    check("mul_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_result", ALUResult, 32'd0);
    check("reset_zero", 32'(Zero), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    issue(3'b100, 32'd5, 32'd5, 32'h0000_0000);
    issue(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    issue(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    issue(3'b111, 32'd10, 32'd20, 32'd30);
    start = 1'b0;
    tick();
    check("idle_no_done", 32'(done), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    mul_run(32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'd30, 1'b0);
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h000B_000F, 1'b1);
    tick();
    check("after_mul_result", ALUResult, 32'h0000_0001);

    start = 1'b1; ALUControl = 3'b101; SrcA = 32'd5; SrcB = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      check("abort_busy", 32'(busy), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_result", ALUResult, 32'd0);
    check("abort_zero", 32'(Zero), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_no_late_done", 32'(done), 32'd0);
    issue(3'b010, 32'd2, 32'd3, 32'd5);
    start = 1'b0;

    mul_run(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'd5, 1'b0);
    check("mulzero_zero", 32'(Zero), 32'd1);
    issue(3'b010, 32'd1, 32'd1, 32'd2);
    start = 1'b0;
    tick();
    check("final_done_low", 32'(done), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_seq_alu.md
# mips_seq_alu

Registered execute-stage ALU that consumes the 3-bit ALUControl code produced by the control unit, together with the two operand buses from the register file / immediate mux. Logic and add/sub/slt operations complete in one clock; MUL (ALUControl 3'b101) runs an iterative shift-add multiplier and raises `busy` so the datapath can stall PC and register-file writeback until `done`.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk  input  1`: single clock; all state updates on the rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `start  input  1`: operation request; sampled only when `busy`=0.
- `ALUControl  input  3`: operation code. 000 AND, 001 OR, 010 ADD, 100 SUB, 110 SLT, 101 MUL; 011 and 111 execute as ADD.
- `SrcA  input  WIDTH`: operand A.
- `SrcB  input  WIDTH`: operand B.
- `ALUResult  output  WIDTH`: registered result; holds until the next completion.
- `Zero  output  1`: registered, 1 when `ALUResult` == 0; updated with `ALUResult`.
- `busy  output  1`: 1 while a MUL is in progress.
- `done  output  1`: one-cycle pulse marking a new valid `ALUResult`.

## Operation
- States: IDLE, MUL.
- IDLE, `start`=1, non-MUL code: compute and register the result at that edge; `done`=1 for the next cycle; stay in IDLE.
- IDLE, `start`=1, MUL: latch multiplicand=SrcA, multiplier=SrcB; clear the accumulator and iteration counter; go to MUL.
- MUL, each edge:
  - If multiplier[0]=1, add the multiplicand to the accumulator (mod 2^WIDTH).
  - Shift the multiplicand left 1 and the multiplier right 1 (logical).
  - Increment the counter.
- On the final iteration edge (counter = WIDTH-1): write accumulator+partial to `ALUResult`, update `Zero`, pulse `done`, return to IDLE.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare, giving {WIDTH-1 zeros, A<B}.
  - MUL returns the low WIDTH bits of the product, which are identical for signed and unsigned operands.
- `start` while `busy`=1 is ignored; no queueing. Operand changes during MUL have no effect.
- `start` in the same cycle that `done` is asserted is accepted normally, because the block is already in IDLE.
- Reset values: state IDLE, `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0, counter=0.
- Reset during MUL aborts the operation: no `done` pulse, and `ALUResult` becomes 0.

## Timing
- Single-cycle ops: `start` sampled at edge E; `ALUResult`, `Zero` and `done`=1 are valid after E+1 (latency 1). Back-to-back requests on every cycle are supported.
- MUL, iterative (default): `start` at edge E.
  - `busy`=1 after E through E+31.
  - At E+32: `busy`=0, `done`=1, result valid (latency 32).
  - Throughput is one MUL per 32 cycles; a new `start` can be accepted at edge E+32.
- `done` is exactly one cycle wide. `busy` and `done` are never 1 in the same cycle.

## Configuration
- `MIPS_ALU_RADIX4_MUL_EN`:
  - Defined: MUL retires 2 multiplier bits per edge, adding 0/1/2/3 x multiplicand and shifting by 2. Final iteration at counter = WIDTH/2-1, so latency is 16 and `busy` is high after E through E+15.
  - Undefined: radix-2 behaviour as described above, latency 32.
- Results, reset values and single-cycle op timing are identical in both builds.

## Test plan
- Reset, then idle: `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0.
- ADD 0x7FFFFFFF+1 -> 0x80000000 next cycle; SUB 5-5 -> 0 with `Zero`=1; SLT 0xFFFFFFFF vs 1 -> 1; AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0. Issue all back-to-back with one `done` per cycle.
- MUL 0x00010003 x 0x00020005 -> 0x000B000F.
  - `busy` high for exactly 32 cycles (16 with the macro), then a single `done` with the result.
  - MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- `start` with ADD asserted during MUL `busy`: ignored; only the MUL result appears; `ALUResult` is unchanged before `done`.
- `rst` at the 10th MUL cycle: `busy`=0 and `ALUResult`=0 next cycle, no `done`. A following ADD 2+3 -> 5 with latency 1.
- MUL x 0 -> `ALUResult`=0, `Zero`=1. `start` (ADD 1+1) in the `done` cycle is accepted: 2 appears on the next cycle.
